// File: rtl/load_align_unit.sv
// Load aligner: fetches the aligned word over req/gnt/rvalid, lane-selects and extends; accept->mem_req 1 cycle, rvalid->rsp 1 cycle.
// Holds rsp stable until rsp_ready, no new request until then; `LOAD_WORD_CACHE_EN adds a one-word hit buffer.
module load_align_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        inv_valid,
  input  logic [31:0] inv_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [4:0]  rd_q, rd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic        accept;
  logic        req_err;
  logic        hit;
  logic [31:0] hit_data;

  function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] off,
                                      input logic [1:0] sz, input logic sg);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'd1:    fmt = {{16{sg & h[15]}}, h};
      2'd2:    fmt = {{24{sg & b[7]}}, b};
      default: fmt = w;
    endcase
  endfunction

  assign accept  = req_valid && req_ready;
  assign req_err = (req_size == 2'd3) ||
                   ((req_size == 2'd1) && req_addr[0]) ||
                   ((req_size == 2'd0) && (req_addr[1:0] != 2'b00));

`ifdef LOAD_WORD_CACHE_EN
  logic        cv_q, cv_d;
  logic [29:0] ctag_q, ctag_d;
  logic [31:0] cword_q, cword_d;
  logic        inv_hit;
  logic        fill;

  // An invalidate that matches in the same cycle as a lookup forces a miss.
  assign inv_hit  = inv_valid && cv_q && (inv_addr[31:2] == ctag_q);
  assign hit      = cv_q && !inv_hit && (req_addr[31:2] == ctag_q);
  assign hit_data = fmt(cword_q, req_addr[1:0], req_size, req_signed);
  assign fill     = (state_q == S_WAIT) && mem_rvalid;

  always_comb begin
    cv_d    = cv_q;
    ctag_d  = ctag_q;
    cword_d = cword_q;
    if (inv_hit) cv_d = 1'b0;
    if (fill) begin
      cv_d    = !(inv_valid && (inv_addr[31:2] == addr_q[31:2]));
      ctag_d  = addr_q[31:2];
      cword_d = mem_rdata;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cv_q    <= 1'b0;
      ctag_q  <= '0;
      cword_q <= '0;
    end else begin
      cv_q    <= cv_d;
      ctag_q  <= ctag_d;
      cword_q <= cword_d;
    end
  end
`else
  logic unused_inv;
  assign unused_inv = ^{inv_valid, inv_addr};
  assign hit        = 1'b0;
  assign hit_data   = '0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (req_err || hit) ? S_RESP : S_ISSUE;
      S_ISSUE: if (mem_gnt) state_d = S_WAIT;
      S_WAIT:  if (mem_rvalid || (cnt_q == CNT_LAST)) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    mem_req   = (state_q == S_ISSUE);
    mem_addr  = (state_q == S_ISSUE) ? {addr_q[31:2], 2'b00} : 32'd0;
    rsp_valid = (state_q == S_RESP);
  end

  always_comb begin
    addr_d     = addr_q;
    size_d     = size_q;
    signed_d   = signed_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d   = req_addr;
          size_d   = req_size;
          signed_d = req_signed;
          rd_d     = req_rd;
          cnt_d    = '0;
          if (req_err) begin
            rsp_err_d  = 1'b1;
            rsp_data_d = '0;
          end else if (hit) begin
            rsp_err_d  = 1'b0;
            rsp_data_d = hit_data;
          end
        end
      end
      S_WAIT: begin
        // Data arriving on the expiry cycle takes priority over the timeout.
        if (mem_rvalid) begin
          rsp_err_d  = 1'b0;
          rsp_data_d = fmt(mem_rdata, addr_q[1:0], size_q, signed_q);
        end else if (cnt_q == CNT_LAST) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      addr_q     <= '0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      rd_q       <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_rd   = rd_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: randomized loads against an arithmetic model of lane select/extension and a word-buffer model.
module tb_load_align_unit;

`ifdef LOAD_WORD_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic        Clk, Reset_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [4:0]  req_rd;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        inv_valid;
  logic [31:0] inv_addr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_err;

  load_align_unit #(.TIMEOUT_CYCLES(15)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_size(req_size), .req_signed(req_signed), .req_rd(req_rd),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .inv_valid(inv_valid), .inv_addr(inv_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;

  // Model state: what the response must be, and whether the unit is busy.
  bit          exp_busy  = 1'b0;
  bit          exp_armed = 1'b0;
  logic [31:0] exp_data  = '0;
  logic [4:0]  exp_rd    = '0;
  logic        exp_err   = 1'b0;
  bit          cv        = 1'b0;
  int unsigned ctag      = 0;
  logic [31:0] cword     = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    chk_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
  endtask

  function automatic bit model_err(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd0 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] model_fmt(input logic [31:0] w, input logic [31:0] a,
                                            input logic [1:0] sz, input logic sg);
    longint v, off, nbits;
    if (sz == 2'd0) return w;
    nbits = (sz == 2'd2) ? 8 : 16;
    off   = longint'(a % 4);
    v     = w;
    v     = (v >> (8 * off)) % (longint'(1) << nbits);
    if (sg && v >= (longint'(1) << (nbits - 1))) v = v - (longint'(1) << nbits);
    return 32'(v);
  endfunction

  always @(negedge Clk) begin
    if (Reset_n) begin
      check("req_ready", {31'd0, req_ready}, {31'd0, !exp_busy});
      if (rsp_valid) begin
        if (!exp_armed) check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
        else begin
          check("rsp_data", rsp_data, exp_data);
          check("rsp_rd", {27'd0, rsp_rd}, {27'd0, exp_rd});
          check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        end
      end
    end
  end

  // Called just after a negedge. rv_dly >= 15 means memory never answers.
  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                         input logic [4:0] rd, input int gnt_dly, input int rv_dly,
                         input logic [31:0] word, input int rdy_dly,
                         input bit lit_en, input logic [31:0] lit);
    bit err, hit;
    int n;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (!req_ready) check("req_ready_wait", 32'd0, 32'd1);
    req_valid  = 1'b1;
    req_addr   = a;
    req_size   = sz;
    req_signed = sg;
    req_rd     = rd;
    @(posedge Clk);
    err      = model_err(a, sz);
    hit      = CACHE_EN && !err && cv && (a / 4 == ctag);
    exp_busy = 1'b1;
    exp_rd   = rd;
    if (err) begin
      exp_data  = '0;
      exp_err   = 1'b1;
      exp_armed = 1'b1;
    end else if (hit) begin
      exp_data  = model_fmt(cword, a, sz, sg);
      exp_err   = 1'b0;
      exp_armed = 1'b1;
    end
    @(negedge Clk);
    req_valid = 1'b0;
    if (err || hit) begin
      check("fast_rsp_lat", {31'd0, rsp_valid}, 32'd1);
      check("fast_no_memreq", {31'd0, mem_req}, 32'd0);
    end else begin
      check("memreq_lat", {31'd0, mem_req}, 32'd1);
      check("mem_addr", mem_addr, (a / 4) * 4);
      repeat (gnt_dly) begin
        @(negedge Clk);
        check("memreq_hold", {31'd0, mem_req}, 32'd1);
      end
      mem_gnt = 1'b1;
      @(negedge Clk);
      mem_gnt = 1'b0;
      check("memreq_drop", {31'd0, mem_req}, 32'd0);
      if (rv_dly < 15) begin
        repeat (rv_dly) @(negedge Clk);
        mem_rvalid = 1'b1;
        mem_rdata  = word;
        @(posedge Clk);
        exp_data  = model_fmt(word, a, sz, sg);
        exp_err   = 1'b0;
        exp_armed = 1'b1;
        cv        = 1'b1;
        ctag      = a / 4;
        cword     = word;
        @(negedge Clk);
        mem_rvalid = 1'b0;
        check("rvalid_rsp_lat", {31'd0, rsp_valid}, 32'd1);
      end else begin
        repeat (14) @(negedge Clk);
        @(posedge Clk);
        exp_data  = '0;
        exp_err   = 1'b1;
        exp_armed = 1'b1;
        @(negedge Clk);
        check("timeout_lat", {31'd0, rsp_valid}, 32'd1);
      end
    end
    if (lit_en) check("lit_data", rsp_data, lit);
    repeat (rdy_dly) begin
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
      @(negedge Clk);
    end
    mem_rvalid = 1'b0;
    rsp_ready  = 1'b1;
    @(posedge Clk);
    exp_armed = 1'b0;
    exp_busy  = 1'b0;
    @(negedge Clk);
    rsp_ready = 1'b0;
  endtask

  task automatic do_inv(input logic [31:0] a);
    inv_valid = 1'b1;
    inv_addr  = a;
    @(posedge Clk);
    if (CACHE_EN && cv && (a / 4 == ctag)) cv = 1'b0;
    @(negedge Clk);
    inv_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    int          rv;
    Reset_n = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_size = '0; req_signed = 1'b0; req_rd = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    inv_valid = 1'b0; inv_addr = '0; rsp_ready = 1'b0;
    #3;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_rd", {27'd0, rsp_rd}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);

    do_load(32'h100, 2'd0, 1'b0, 5'd7, 0, 2, 32'hDEADBEEF, 0, 1'b1, 32'hDEADBEEF);

    // Reset in the middle of WAIT, then a stray rvalid must be ignored.
    req_valid = 1'b1; req_addr = 32'h500; req_size = 2'd0; req_rd = 5'd3;
    @(posedge Clk);
    exp_busy = 1'b1;
    @(negedge Clk);
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge Clk);
    mem_gnt = 1'b0;
    repeat (3) @(negedge Clk);
    #2;
    Reset_n  = 1'b0;
    exp_busy = 1'b0;
    cv       = 1'b0;
    #1;
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst_rsp_data", rsp_data, 32'd0);
    check("midrst_rsp_rd", {27'd0, rsp_rd}, 32'd0);
    check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge Clk);
    Reset_n = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h12345678;
    @(negedge Clk);
    mem_rvalid = 1'b0;
    repeat (2) @(negedge Clk);
    do_load(32'h500, 2'd0, 1'b0, 5'd3, 1, 1, 32'hCAFEF00D, 0, 1'b1, 32'hCAFEF00D);

    do_load(32'h200, 2'd2, 1'b1, 5'd1, 0, 0, 32'h80FF7F01, 0, 1'b1, 32'h00000001);
    do_load(32'h201, 2'd2, 1'b1, 5'd2, 1, 1, 32'h80FF7F01, 1, 1'b1, 32'h0000007F);
    do_load(32'h202, 2'd2, 1'b1, 5'd3, 0, 3, 32'h80FF7F01, 0, 1'b1, 32'hFFFFFFFF);
    do_load(32'h203, 2'd2, 1'b1, 5'd4, 2, 0, 32'h80FF7F01, 2, 1'b1, 32'hFFFFFF80);
    do_load(32'h203, 2'd2, 1'b0, 5'd5, 0, 1, 32'h80FF7F01, 0, 1'b1, 32'h00000080);
    do_load(32'h302, 2'd1, 1'b1, 5'd6, 0, 0, 32'h8001F00F, 0, 1'b1, 32'hFFFF8001);
    do_load(32'h300, 2'd1, 1'b0, 5'd8, 0, 2, 32'h8001F00F, 1, 1'b1, 32'h0000F00F);
    do_load(32'h101, 2'd1, 1'b1, 5'd9, 0, 0, 32'h8001F00F, 1, 1'b1, 32'h00000000);
    do_load(32'h107, 2'd3, 1'b0, 5'd10, 0, 0, 32'h0, 0, 1'b1, 32'h00000000);
    do_load(32'h400, 2'd0, 1'b0, 5'd11, 0, 15, 32'h0, 5, 1'b1, 32'h00000000);
    do_load(32'h600, 2'd0, 1'b0, 5'd12, 0, 14, 32'hA5A5_5A5A, 0, 1'b1, 32'hA5A55A5A);

    do_load(32'h104, 2'd0, 1'b0, 5'd13, 0, 2, 32'h11223344, 0, 1'b1, 32'h11223344);
    do_load(32'h104, 2'd2, 1'b0, 5'd14, 0, 2, 32'h11223344, 0, 1'b1, 32'h00000044);
    do_inv(32'h106);
    do_load(32'h104, 2'd0, 1'b0, 5'd15, 0, 1, 32'h55667788, 0, 1'b1, 32'h55667788);

    for (int i = 0; i < 80; i++) begin
      ra = 32'h100 + 32'($urandom_range(0, 31));
      rv = $urandom_range(0, 19);
      if (rv > 14) rv = 15;
      if ($urandom_range(0, 7) == 0) do_inv(32'h100 + 32'($urandom_range(0, 31)));
      do_load(ra, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom),
              $urandom_range(0, 3), rv, $urandom, $urandom_range(0, 3), 1'b0, 32'h0);
    end

    repeat (3) @(negedge Clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
